// File: rtl/tcp_checksum_insert.sv
// tcp_checksum_insert
// Buffers a TCP segment in a beat FIFO until the checksum engine delivers the
// segment's final checksum, then writes that checksum into the header field of
// the first beat and forwards the whole segment on M_AXIS.
//
// The beat FIFO must hold a whole segment: a segment longer than DEPTH beats
// can never be released, because its checksum only arrives after the engine
// has seen its last beat. Keeping segments within DEPTH beats is the upstream
// source's responsibility and is not detected here.
module tcp_checksum_insert #(
  parameter int DEPTH            = 64,  // beats; power of two, >= 4
  parameter int CSUM_BYTE_OFFSET = 16   // byte lane of checksum MSB; <= 62
) (
  input  logic         clk,
  input  logic         rst,
  // Segment input (also broadcast to the checksum engine)
  input  logic [511:0] S_AXIS_TDATA,
  input  logic [63:0]  S_AXIS_TKEEP,
  input  logic         S_AXIS_TVALID,
  input  logic         S_AXIS_TLAST,
  output logic         S_AXIS_TREADY,
  // Checksum tokens, one per segment, in segment order
  input  logic [15:0]  S_CSUM_TDATA,
  input  logic         S_CSUM_TVALID,
  output logic         S_CSUM_TREADY,
  // Patched segment output
  output logic [511:0] M_AXIS_TDATA,
  output logic [63:0]  M_AXIS_TKEEP,
  output logic         M_AXIS_TVALID,
  output logic         M_AXIS_TLAST,
  input  logic         M_AXIS_TREADY,
  // Segments emitted, wrapping
  output logic [31:0]  pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 512 + 64 + 1;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  // Byte-lane insertion of the checksum into a header beat (network order:
  // MSB in the lower lane).
  function automatic logic [511:0] patch_data(input logic [511:0] d,
                                              input logic [15:0]  c);
    logic [511:0] r;
    r = d;
    r[8*CSUM_BYTE_OFFSET +: 8]     = c[15:8];
    r[8*(CSUM_BYTE_OFFSET+1) +: 8] = c[7:0];
    return r;
  endfunction

  // The checksum lanes are always valid on the patched beat.
  function automatic logic [63:0] patch_keep(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    r[CSUM_BYTE_OFFSET]   = 1'b1;
    r[CSUM_BYTE_OFFSET+1] = 1'b1;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Beat FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push, pop, fifo_empty;
  logic [511:0]  head_data;
  logic [63:0]   head_keep;
  logic          head_last;

  // ---------------------------------------------------------------------------
  // Checksum holding register, FSM and output register
  // ---------------------------------------------------------------------------
  logic          csum_full_q, csum_full_d;
  logic [15:0]   csum_q, csum_d;
  logic          csum_load;

  state_t        state_q, state_d;
  logic          slot_free, load_head, load_body, load_out;

  logic [511:0]  m_data_q, m_data_d;
  logic [63:0]   m_keep_q, m_keep_d;
  logic          m_last_q, m_last_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   pkt_count_q, pkt_count_d;

  // Ready is derived from registered occupancy only, so a pop in the same
  // cycle does not open the input; it reopens on the following cycle.
  assign S_AXIS_TREADY = (occ_q != OCC_FULL);
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign fifo_empty    = (occ_q == '0);
  assign pop           = load_out;

  assign {head_data, head_keep, head_last} = mem_q[rd_ptr_q];

  assign S_CSUM_TREADY = !csum_full_q;
  assign csum_load     = S_CSUM_TVALID && !csum_full_q;

  assign slot_free     = !m_valid_q || M_AXIS_TREADY;
  assign load_out      = load_head || load_body;

  // FIFO storage: data is kept exactly as received, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST};
    end
  end

  // FIFO pointer and occupancy next state; push+pop keeps occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Holding register next state: fill on accept, empty when the head beat
  // it belongs to is loaded. Both cannot happen at once since ready is low
  // whenever the register is full.
  always_comb begin
    csum_full_d = csum_full_q;
    csum_d      = csum_q;
    if (csum_load) begin
      csum_full_d = 1'b1;
      csum_d      = S_CSUM_TDATA;
    end else if (load_head) begin
      csum_full_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_full_q <= 1'b0;
      csum_q      <= '0;
    end else begin
      csum_full_q <= csum_full_d;
      csum_q      <= csum_d;
    end
  end

  // FSM next state: HEAD waits for the checksum, BODY streams the rest.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_body = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (csum_full_q && !fifo_empty && slot_free) begin
          load_head = 1'b1;
          state_d   = head_last ? IDLE : BODY;
        end
      end
      BODY: begin
        if (!fifo_empty && slot_free) begin
          load_body = 1'b1;
          if (head_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register next state: the head beat is patched, body beats pass
  // through; an unaccepted beat is held unchanged.
  always_comb begin
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (load_head) begin
      m_data_d  = patch_data(head_data, csum_q);
      m_keep_d  = patch_keep(head_keep);
      m_last_d  = head_last;
      m_valid_d = 1'b1;
    end else if (load_body) begin
      m_data_d  = head_data;
      m_keep_d  = head_keep;
      m_last_d  = head_last;
      m_valid_d = 1'b1;
    end else if (M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  // Segment counter next state: counts accepted last beats, wrapping.
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (m_valid_q && M_AXIS_TREADY && m_last_q) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  // Output register and segment counter; outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TKEEP  = m_keep_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_tcp_checksum_insert.sv
// Directed bench for tcp_checksum_insert: each scenario task drives its own
// stimulus and compares outputs against hand-derived expectations.
module tb_tcp_checksum_insert;

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         rst;
  logic [511:0] S_AXIS_TDATA;
  logic [63:0]  S_AXIS_TKEEP;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;
  logic [15:0]  S_CSUM_TDATA;
  logic         S_CSUM_TVALID;
  logic         S_CSUM_TREADY;
  logic [511:0] M_AXIS_TDATA;
  logic [63:0]  M_AXIS_TKEEP;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY;
  logic [31:0]  pkt_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int segs_sent = 0;
  int last_acc_cyc = 0;
  int csum_acc_cyc = 0;

  logic [511:0] cap_d[$];
  logic [63:0]  cap_k[$];
  logic         cap_l[$];
  int           cap_c[$];

  tcp_checksum_insert #(.DEPTH(64), .CSUM_BYTE_OFFSET(16)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_CSUM_TDATA(S_CSUM_TDATA), .S_CSUM_TVALID(S_CSUM_TVALID),
    .S_CSUM_TREADY(S_CSUM_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output beat that will be accepted at the next rising edge.
  always @(negedge clk) begin
    if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
      cap_d.push_back(M_AXIS_TDATA);
      cap_k.push_back(M_AXIS_TKEEP);
      cap_l.push_back(M_AXIS_TLAST);
      cap_c.push_back(cyc);
    end
  end

  function automatic logic [511:0] mk_data(input int seg, input int beat);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'((seg*29 + beat*11 + i*3 + 5) & 255);
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_CSUM_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_c.delete();
    segs_sent = 0;
  endtask

  task automatic send_seg(input int seg, input int n, input logic [63:0] keep0,
                          input bit zero_hdr, input bit with_last);
    for (int b = 0; b < n; b++) begin
      logic [511:0] d;
      bit acc;
      int w;
      d = mk_data(seg, b);
      if (b == 0 && zero_hdr) d[143:128] = 16'h0000;
      S_AXIS_TDATA  = d;
      S_AXIS_TKEEP  = (b == 0) ? keep0 : ALL;
      S_AXIS_TLAST  = with_last && (b == n - 1);
      S_AXIS_TVALID = 1'b1;
      acc = 1'b0; w = 0;
      while (!acc && w < 5000) begin
        @(negedge clk); acc = S_AXIS_TREADY;
        @(posedge clk); #1; w++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL s_axis_accept seg %0d beat %0d got no ready within %0d cycles", seg, b, w);
      end
    end
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    segs_sent++;
    last_acc_cyc = cyc;
  endtask

  task automatic send_csum(input logic [15:0] v);
    bit acc;
    int w;
    S_CSUM_TDATA = v; S_CSUM_TVALID = 1'b1;
    acc = 1'b0; w = 0;
    while (!acc && w < 5000) begin
      @(negedge clk); acc = S_CSUM_TREADY;
      @(posedge clk); #1; w++;
    end
    S_CSUM_TVALID = 1'b0;
    csum_acc_cyc = cyc;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL s_csum_accept %h got no ready within %0d cycles", v, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0;
    S_CSUM_TVALID = 1'b0; S_CSUM_TDATA = '0; M_AXIS_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", M_AXIS_TDATA); end
    checks++; if (M_AXIS_TKEEP !== '0) begin errors++; $display("FAIL reset_tkeep got %h exp 0", M_AXIS_TKEEP); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", M_AXIS_TLAST); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL reset_s_tready got %b exp 1", S_AXIS_TREADY); end
    checks++; if (S_CSUM_TREADY !== 1'b1) begin errors++; $display("FAIL reset_csum_tready got %b exp 1", S_CSUM_TREADY); end
  endtask

  task automatic test_single_beat();
    logic [511:0] e;
    do_reset();
    send_seg(1, 1, ALL, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1 send_csum(16'hBEEF);
    for (int i = 0; i < 100 && cap_d.size() < 1; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    e = mk_data(1, 0);
    e[135:128] = 8'hBE; e[143:136] = 8'hEF;
    checks++;
    if (cap_d.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", cap_d.size()); end
    else begin
      checks++; if (cap_d[0][135:128] !== 8'hBE) begin errors++; $display("FAIL single_byte16 got %h exp be", cap_d[0][135:128]); end
      checks++; if (cap_d[0][143:136] !== 8'hEF) begin errors++; $display("FAIL single_byte17 got %h exp ef", cap_d[0][143:136]); end
      checks++; if (cap_d[0] !== e) begin errors++; $display("FAIL single_data got %h exp %h", cap_d[0], e); end
      checks++; if (cap_k[0] !== ALL) begin errors++; $display("FAIL single_keep got %h exp %h", cap_k[0], ALL); end
      checks++; if (cap_l[0] !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", cap_l[0]); end
      checks++; if (cap_c[0] != csum_acc_cyc + 1) begin errors++; $display("FAIL single_latency got cycle %0d exp %0d", cap_c[0], csum_acc_cyc + 1); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL single_tvalid_drop got %b exp 0", M_AXIS_TVALID); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] e [5];
    logic         el [5];
    do_reset();
    fork
      begin
        send_seg(2, 3, ALL, 1'b0, 1'b1);
        send_seg(3, 2, ALL, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 200 && segs_sent < 1; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1 send_csum(16'h1234);
        for (int i = 0; i < 200 && segs_sent < 2; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1 send_csum(16'hABCD);
      end
    join
    for (int i = 0; i < 200 && cap_d.size() < 5; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    e[0] = mk_data(2, 0); e[0][135:128] = 8'h12; e[0][143:136] = 8'h34;
    e[1] = mk_data(2, 1);
    e[2] = mk_data(2, 2);
    e[3] = mk_data(3, 0); e[3][135:128] = 8'hAB; e[3][143:136] = 8'hCD;
    e[4] = mk_data(3, 1);
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b1; el[3] = 1'b0; el[4] = 1'b1;
    checks++;
    if (cap_d.size() != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", cap_d.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cap_d[i] !== e[i]) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", i, cap_d[i], e[i]); end
        checks++; if (cap_l[i] !== el[i]) begin errors++; $display("FAIL b2b_last beat %0d got %b exp %b", i, cap_l[i], el[i]); end
      end
      checks++; if (cap_c[1] != cap_c[0] + 1 || cap_c[2] != cap_c[1] + 1 || cap_c[4] != cap_c[3] + 1) begin
        errors++; $display("FAIL b2b_throughput got cycles %0d %0d %0d / %0d %0d exp consecutive", cap_c[0], cap_c[1], cap_c[2], cap_c[3], cap_c[4]);
      end
      checks++; if (cap_c[3] != cap_c[2] + 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", cap_c[3] - cap_c[2]); end
    end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL b2b_pkt_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_fill();
    logic [511:0] e;
    int bad;
    do_reset();
    send_seg(7, 64, ALL, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL fill_s_tready_full got %b exp 0", S_AXIS_TREADY); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL fill_m_tvalid_wait got %b exp 0", M_AXIS_TVALID); end
    @(posedge clk);
    #1 send_csum(16'h0F0F);
    @(negedge clk);
    checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL fill_s_tready_before_pop got %b exp 0", S_AXIS_TREADY); end
    @(negedge clk);
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL fill_s_tready_after_pop got %b exp 1", S_AXIS_TREADY); end
    for (int i = 0; i < 400 && cap_d.size() < 64; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (cap_d.size() != 64) begin errors++; $display("FAIL fill_count got %0d exp 64", cap_d.size()); end
    else begin
      bad = 0;
      for (int b = 0; b < 64; b++) begin
        e = mk_data(7, b);
        if (b == 0) begin e[135:128] = 8'h0F; e[143:136] = 8'h0F; end
        checks++;
        if (cap_d[b] !== e || cap_l[b] !== (b == 63)) begin
          errors++; $display("FAIL fill_beat %0d got last %b data %h exp last %b data %h", b, cap_l[b], cap_d[b], (b == 63), e);
        end
      end
      checks++; if (cap_c[63] != cap_c[0] + 63) begin errors++; $display("FAIL fill_throughput got %0d cycles exp 63", cap_c[63] - cap_c[0]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL fill_pkt_count got %0d exp 1", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [511:0] e;
    do_reset();
    fork
      send_seg(4, 4, ALL, 1'b0, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 send_csum(16'hC0DE);
      end
      begin
        bit prev_stall;
        logic [511:0] pd;
        logic pl;
        int nstall;
        prev_stall = 1'b0; nstall = 0; pd = '0; pl = 1'b0;
        for (int i = 0; i < 300 && cap_d.size() < 4; i++) begin
          if (M_AXIS_TVALID && nstall < 2) begin M_AXIS_TREADY = 1'b0; nstall++; end
          else M_AXIS_TREADY = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== pd || M_AXIS_TLAST !== pl) begin
              errors++; $display("FAIL bp_stable got valid %b last %b data %h exp valid 1 last %b data %h", M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, pl, pd);
            end
          end
          prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
          pd = M_AXIS_TDATA; pl = M_AXIS_TLAST;
          @(posedge clk);
          #1;
        end
        M_AXIS_TREADY = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cap_d.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", cap_d.size()); end
    else begin
      for (int b = 0; b < 4; b++) begin
        e = mk_data(4, b);
        if (b == 0) begin e[135:128] = 8'hC0; e[143:136] = 8'hDE; end
        checks++;
        if (cap_d[b] !== e || cap_l[b] !== (b == 3)) begin
          errors++; $display("FAIL bp_beat %0d got last %b data %h exp last %b data %h", b, cap_l[b], cap_d[b], (b == 3), e);
        end
      end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL bp_pkt_count got %0d exp 1", pkt_count); end
  endtask

  task automatic test_csum_early();
    logic [511:0] e;
    int c2acc;
    do_reset();
    c2acc = 0;
    send_csum(16'h5555);
    @(negedge clk);
    checks++; if (S_CSUM_TREADY !== 1'b0) begin errors++; $display("FAIL early_csum_held got %b exp 0", S_CSUM_TREADY); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL early_no_output got %b exp 0", M_AXIS_TVALID); end
    @(posedge clk);
    #1;
    fork
      begin
        send_csum(16'h6666);
        c2acc = csum_acc_cyc;
      end
      begin
        repeat (3) @(posedge clk);
        #1 send_seg(5, 2, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1);
        send_seg(6, 1, ALL, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(negedge clk);
        checks++; if (S_CSUM_TREADY !== 1'b0) begin errors++; $display("FAIL early_second_blocked got %b exp 0", S_CSUM_TREADY); end
      end
    join
    for (int i = 0; i < 200 && cap_d.size() < 3; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (cap_d.size() != 3) begin errors++; $display("FAIL early_count got %0d exp 3", cap_d.size()); end
    else begin
      checks++; if (c2acc != cap_c[0] + 1) begin errors++; $display("FAIL early_second_accept got cycle %0d exp %0d", c2acc, cap_c[0] + 1); end
      e = mk_data(5, 0); e[135:128] = 8'h55; e[143:136] = 8'h55;
      checks++; if (cap_d[0] !== e) begin errors++; $display("FAIL early_seg1_head got %h exp %h", cap_d[0], e); end
      checks++; if (cap_k[0] !== 64'h0000_0000_0003_FFFF) begin errors++; $display("FAIL early_seg1_keep got %h exp 3ffff", cap_k[0]); end
      e = mk_data(5, 1);
      checks++; if (cap_d[1] !== e || cap_k[1] !== ALL || cap_l[1] !== 1'b1) begin errors++; $display("FAIL early_seg1_body got last %b keep %h data %h exp last 1 data %h", cap_l[1], cap_k[1], cap_d[1], e); end
      e = mk_data(6, 0); e[135:128] = 8'h66; e[143:136] = 8'h66;
      checks++; if (cap_d[2] !== e || cap_l[2] !== 1'b1) begin errors++; $display("FAIL early_seg2_head got last %b data %h exp last 1 data %h", cap_l[2], cap_d[2], e); end
    end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL early_pkt_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] e;
    do_reset();
    M_AXIS_TREADY = 1'b0;
    send_seg(8, 2, ALL, 1'b0, 1'b0);
    send_csum(16'h9999);
    send_csum(16'hAAAA);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (M_AXIS_TVALID !== 1'b1 || S_CSUM_TREADY !== 1'b0) begin
      errors++; $display("FAIL mid_pre_state got tvalid %b csum_tready %b exp 1 0", M_AXIS_TVALID, S_CSUM_TREADY);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b exp 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== '0 || M_AXIS_TKEEP !== '0 || M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL mid_outputs got keep %h last %b exp 0 0", M_AXIS_TKEEP, M_AXIS_TLAST); end
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL mid_s_tready got %b exp 1", S_AXIS_TREADY); end
    checks++; if (S_CSUM_TREADY !== 1'b1) begin errors++; $display("FAIL mid_csum_tready got %b exp 1", S_CSUM_TREADY); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_pkt_count_reset got %0d exp 0", pkt_count); end
    M_AXIS_TREADY = 1'b1;
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_c.delete();
    @(posedge clk);
    #1;
    fork
      send_seg(9, 1, ALL, 1'b0, 1'b1);
      send_csum(16'h7777);
    join
    for (int i = 0; i < 100 && cap_d.size() < 1; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    e = mk_data(9, 0); e[135:128] = 8'h77; e[143:136] = 8'h77;
    checks++;
    if (cap_d.size() != 1) begin errors++; $display("FAIL mid_count got %0d exp 1", cap_d.size()); end
    else begin
      checks++; if (cap_d[0] !== e || cap_l[0] !== 1'b1) begin errors++; $display("FAIL mid_fresh_beat got last %b data %h exp last 1 data %h", cap_l[0], cap_d[0], e); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL mid_pkt_count got %0d exp 1", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_fill();
    test_backpressure();
    test_csum_early();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
